// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the fetch unit, instruction memory and decode.
package instruction_fetch_unit_pkg;

    localparam int L_DEFAULT = 16;
    localparam logic [L_DEFAULT-1:0] RESET_PC_DEFAULT = 16'h0000;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_output_stage.sv
// One-entry valid/ready register holding a fetched instruction and its PC.
module instruction_fetch_unit_output_stage
    import instruction_fetch_unit_pkg::*;
#(
    parameter int L = L_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         capture,
    input  logic         flush,
    input  logic         accept,
    input  logic [L-1:0] in_instruction,
    input  logic [L-1:0] in_pc,
    output logic         out_valid,
    output logic [L-1:0] out_instruction,
    output logic [L-1:0] out_pc
);

    logic         valid_r;
    logic [L-1:0] instruction_r;
    logic [L-1:0] pc_r;

    // Flush beats capture, capture beats drain; data is kept when the entry leaves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r       <= 1'b0;
            instruction_r <= '0;
            pc_r          <= '0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (capture) begin
            valid_r       <= 1'b1;
            instruction_r <= in_instruction;
            pc_r          <= in_pc;
        end else if (accept) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign out_valid       = valid_r;
    assign out_instruction = instruction_r;
    assign out_pc          = pc_r;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, drives the memory address and feeds decode
// through a one-entry output stage with redirect and halt/resume support.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int         L        = L_DEFAULT,
    parameter logic [L-1:0] RESET_PC = L'(RESET_PC_DEFAULT),
    parameter int         COUNT_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    output logic [L-1:0]       imem_address,
    input  logic [L-1:0]       imem_instruction,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [L-1:0]       out_instruction,
    output logic [L-1:0]       out_pc,
    input  logic               redirect_valid,
    input  logic [L-1:0]       redirect_target,
    input  logic               halt,
    output logic               halted,
    output logic [COUNT_W-1:0] fetch_count
);

    localparam logic [L-1:0]       PC_ONE    = {{(L-1){1'b0}}, 1'b1};
    localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    fetch_state_t       state_r;
    fetch_state_t       state_next_s;
    logic [L-1:0]       pc_r;
    logic [L-1:0]       pc_next_s;
    logic [COUNT_W-1:0] fetch_count_r;
    logic               out_valid_s;
    logic               accept_s;
    logic               slot_free_s;
    logic               capture_s;
    logic               flush_s;

    assign accept_s    = out_valid_s & out_ready;
    assign slot_free_s = ~out_valid_s | accept_s;

    // State and PC registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= FETCH;
            pc_r    <= RESET_PC;
        end else begin
            state_r <= state_next_s;
            pc_r    <= pc_next_s;
        end
    end

    // Next-state decode; redirect outranks halt in both states.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        capture_s    = 1'b0;
        flush_s      = 1'b0;
        case (state_r)
            FETCH: begin
                if (redirect_valid) begin
                    pc_next_s = redirect_target;
                    flush_s   = 1'b1;
                end else if (halt) begin
                    state_next_s = HALTED;
                end else if (slot_free_s) begin
                    capture_s = 1'b1;
                    pc_next_s = pc_r + PC_ONE;
                end else begin
                    pc_next_s = pc_r;
                end
            end
            HALTED: begin
                if (redirect_valid) begin
                    pc_next_s    = redirect_target;
                    state_next_s = FETCH;
                    flush_s      = 1'b1;
                end else begin
                    state_next_s = HALTED;
                end
            end
            default: begin
                state_next_s = FETCH;
                pc_next_s    = RESET_PC;
                flush_s      = 1'b1;
            end
        endcase
    end

    // Retired-fetch counter; a handshake counts even when a redirect flushes the slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count_r <= '0;
        end else if (accept_s) begin
            fetch_count_r <= fetch_count_r + COUNT_ONE;
        end else begin
            fetch_count_r <= fetch_count_r;
        end
    end

    instruction_fetch_unit_output_stage #(
        .L(L)
    ) u_output_stage (
        .clk            (clk),
        .reset          (reset),
        .capture        (capture_s),
        .flush          (flush_s),
        .accept         (accept_s),
        .in_instruction (imem_instruction),
        .in_pc          (pc_r),
        .out_valid      (out_valid_s),
        .out_instruction(out_instruction),
        .out_pc         (out_pc)
    );

    assign imem_address = pc_r;
    assign out_valid    = out_valid_s;
    assign halted       = (state_r == HALTED);
    assign fetch_count  = fetch_count_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed vector bench for instruction_fetch_unit with a word-addressed memory model.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset;
    logic [15:0] imem_address;
    logic [15:0] imem_instruction;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instruction;
    logic [15:0] out_pc;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic        halt;
    logic        halted;
    logic [15:0] fetch_count;

    logic [15:0] mem [0:65535];

    int tests;
    int fails;

    typedef struct {
        logic        rv;
        logic [15:0] rt;
        logic        h;
        logic        rdy;
        logic        e_valid;
        logic        chk_data;
        logic [15:0] e_pc;
        logic [15:0] e_instr;
        logic        e_halted;
        logic [15:0] e_count;
        logic [15:0] e_addr;
    } vec_t;

    vec_t vecs [0:26];
    int   nvec;

    instruction_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .imem_address    (imem_address),
        .imem_instruction(imem_instruction),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt            (halt),
        .halted          (halted),
        .fetch_count     (fetch_count)
    );

    assign imem_instruction = mem[imem_address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rv, input logic [15:0] rt, input logic h, input logic rdy,
                       input logic ev, input logic cd, input logic [15:0] epc,
                       input logic [15:0] ein, input logic eh, input logic [15:0] ec,
                       input logic [15:0] ea);
        vecs[nvec].rv       = rv;
        vecs[nvec].rt       = rt;
        vecs[nvec].h        = h;
        vecs[nvec].rdy      = rdy;
        vecs[nvec].e_valid  = ev;
        vecs[nvec].chk_data = cd;
        vecs[nvec].e_pc     = epc;
        vecs[nvec].e_instr  = ein;
        vecs[nvec].e_halted = eh;
        vecs[nvec].e_count  = ec;
        vecs[nvec].e_addr   = ea;
        nvec++;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        nvec  = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h1000 + 16'(i);

        //   rv    rt        h     rdy   valid cd    out_pc    instr     halted count   addr
        add(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h1000, 1'b0, 16'd0,  16'h0001);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0001, 16'h1001, 1'b0, 16'd1,  16'h0002);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0002, 16'h1002, 1'b0, 16'd2,  16'h0003);
        add(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0002, 16'h1002, 1'b0, 16'd2,  16'h0003);
        add(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0002, 16'h1002, 1'b0, 16'd2,  16'h0003);
        add(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0002, 16'h1002, 1'b0, 16'd2,  16'h0003);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0003, 16'h1003, 1'b0, 16'd3,  16'h0004);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0004, 16'h1004, 1'b0, 16'd4,  16'h0005);
        // redirect while entry 4 is accepted: flush, bubble, then target
        add(1'b1, 16'h0020, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'd5,  16'h0020);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0020, 16'h1020, 1'b0, 16'd5,  16'h0021);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0021, 16'h1021, 1'b0, 16'd6,  16'h0022);
        // halt with a stalled entry, drain it, then resume by redirect
        add(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0021, 16'h1021, 1'b1, 16'd6,  16'h0022);
        add(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0021, 16'h1021, 1'b1, 16'd6,  16'h0022);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'd7,  16'h0022);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'd7,  16'h0022);
        add(1'b1, 16'h0030, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'd7,  16'h0030);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0030, 16'h1030, 1'b0, 16'd7,  16'h0031);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0031, 16'h1031, 1'b0, 16'd8,  16'h0032);
        // redirect and halt together: redirect wins; then PC wraps past 0xFFFF
        add(1'b1, 16'hFFFE, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'd9,  16'hFFFE);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFE, 16'h0FFE, 1'b0, 16'd9,  16'hFFFF);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFF, 16'h0FFF, 1'b0, 16'd10, 16'h0000);
        add(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h1000, 1'b0, 16'd11, 16'h0001);
        // halt while the entry is accepted: drains, no new capture, halt ignored once halted
        add(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'd12, 16'h0001);
        add(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'd12, 16'h0001);
        add(1'b1, 16'h0040, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'd12, 16'h0040);
        add(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0040, 16'h1040, 1'b0, 16'd12, 16'h0041);
        add(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0040, 16'h1040, 1'b0, 16'd12, 16'h0041);

        reset           = 1'b1;
        out_ready       = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 16'h0000;
        halt            = 1'b0;

        #8;
        check("reset_valid",  {31'd0, out_valid}, 32'd0);
        check("reset_halted", {31'd0, halted}, 32'd0);
        check("reset_count",  {16'd0, fetch_count}, 32'd0);
        check("reset_addr",   {16'd0, imem_address}, 32'd0);
        check("reset_pc",     {16'd0, out_pc}, 32'd0);
        check("reset_instr",  {16'd0, out_instruction}, 32'd0);
        #4;
        reset = 1'b0;

        for (int i = 0; i < nvec; i++) begin
            redirect_valid  = vecs[i].rv;
            redirect_target = vecs[i].rt;
            halt            = vecs[i].h;
            out_ready       = vecs[i].rdy;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid", i),  {31'd0, out_valid}, {31'd0, vecs[i].e_valid});
            check($sformatf("v%0d_halted", i), {31'd0, halted}, {31'd0, vecs[i].e_halted});
            check($sformatf("v%0d_count", i),  {16'd0, fetch_count}, {16'd0, vecs[i].e_count});
            check($sformatf("v%0d_addr", i),   {16'd0, imem_address}, {16'd0, vecs[i].e_addr});
            if (vecs[i].chk_data) begin
                check($sformatf("v%0d_pc", i),    {16'd0, out_pc}, {16'd0, vecs[i].e_pc});
                check($sformatf("v%0d_instr", i), {16'd0, out_instruction}, {16'd0, vecs[i].e_instr});
            end
        end

        // asynchronous reset mid-cycle while a stalled entry is held
        redirect_valid = 1'b0;
        halt           = 1'b0;
        out_ready      = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async_valid",  {31'd0, out_valid}, 32'd0);
        check("async_count",  {16'd0, fetch_count}, 32'd0);
        check("async_halted", {31'd0, halted}, 32'd0);
        check("async_addr",   {16'd0, imem_address}, 32'd0);
        check("async_pc",     {16'd0, out_pc}, 32'd0);

        // async reset while halted
        @(posedge clk);
        #2;
        reset = 1'b0;
        halt  = 1'b1;
        @(posedge clk);
        #1;
        check("halt_again", {31'd0, halted}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_halt_clear", {31'd0, halted}, 32'd0);

        // first edge after release presents RESET_PC
        halt      = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rel_valid", {31'd0, out_valid}, 32'd1);
        check("rel_pc",    {16'd0, out_pc}, 32'd0);
        check("rel_instr", {16'd0, out_instruction}, 32'h1000);
        check("rel_count", {16'd0, fetch_count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
